// File: rtl/dio_slot_bank.sv
// dio_slot_bank
//   Bank of SLOTS general-purpose I/O slots, DW bits each, sitting behind the
//   SPI-slave register bus. Each slot has output, input, direction, sticky
//   interrupt status, interrupt mask, write-1-to-clear and rise/fall enables.
//   Pad inputs pass through a SYNC_STAGES-deep synchroniser plus a "prev"
//   register for edge detection. Edge detection stays disarmed until the
//   synchroniser has flushed after reset. This keeps pads that are already
//   high at reset from raising interrupts.
//
//   Register map (N = SLOTS, s = slot):
//     OUT s+0N  IN s+1N  DIR s+2N  INT_STAT s+3N
//     INT_MASK s+4N  INT_CLR s+5N  RISE_EN s+6N  FALL_EN s+7N
//
// Ports
//   sys_clk     system clock
//   sys_rst     synchronous active-high reset
//   bus_we      write strobe (one cycle)
//   bus_re      read strobe (one cycle)
//   bus_addr    register address
//   bus_wdata   write data
//   bus_rdata   registered read data, held until the next read
//   bus_rvalid  one-cycle pulse, the cycle after bus_re
//   pad_o       pad output values, slot s at [s*DW +: DW]
//   pad_oe      pad output enables, 1 = drive
//   pad_i       asynchronous pad inputs
//   irq         registered OR over all slots of (INT_STAT & INT_MASK)
module dio_slot_bank #(
    parameter int SLOTS       = 1,
    parameter int DW          = 16,
    parameter int AW          = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                bus_we,
    input  logic                bus_re,
    input  logic [AW-1:0]       bus_addr,
    input  logic [DW-1:0]       bus_wdata,
    output logic [DW-1:0]       bus_rdata,
    output logic                bus_rvalid,
    output logic [SLOTS*DW-1:0] pad_o,
    output logic [SLOTS*DW-1:0] pad_oe,
    input  logic [SLOTS*DW-1:0] pad_i,
    output logic                irq
);

    localparam int NW = SLOTS * DW;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_LOAD = CW'(SYNC_STAGES + 1);

    logic [NW-1:0] out_q, dir_q, stat_q, mask_q, rise_en_q, fall_en_q;
    logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
    logic [NW-1:0] prev_q;
    logic [CW-1:0] arm_cnt_q;
    logic          armed;

    logic [7:0][SLOTS-1:0] sel;
    logic [7:0][NW-1:0]    view;
    logic [NW-1:0] we_out, we_dir, we_mask, we_clr, we_rise, we_fall;
    logic [NW-1:0] wvec, sync_v, rise, fall, set_v, clr_v;
    logic [DW-1:0] rd_data;

    assign wvec   = {SLOTS{bus_wdata}};
    assign sync_v = sync_q[SYNC_STAGES-1];

    // Index k of view is register kind k; INT_CLR reads as zero.
    assign view = {fall_en_q, rise_en_q, {NW{1'b0}}, mask_q,
                   stat_q, dir_q, sync_v, out_q};

    // Address decode: at most one (kind, slot) matches, so read data can be
    // OR-combined. Out-of-range addresses match nothing: writes drop, reads give 0.
    always_comb begin
        sel     = '0;
        we_out  = '0;
        we_dir  = '0;
        we_mask = '0;
        we_clr  = '0;
        we_rise = '0;
        we_fall = '0;
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (bus_addr == AW'(k * SLOTS + s)) begin
                    sel[k][s] = 1'b1;
                end
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            we_out[s*DW +: DW]  = {DW{bus_we & sel[0][s]}};
            we_dir[s*DW +: DW]  = {DW{bus_we & sel[2][s]}};
            we_mask[s*DW +: DW] = {DW{bus_we & sel[4][s]}};
            we_clr[s*DW +: DW]  = {DW{bus_we & sel[5][s]}};
            we_rise[s*DW +: DW] = {DW{bus_we & sel[6][s]}};
            we_fall[s*DW +: DW] = {DW{bus_we & sel[7][s]}};
        end
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < SLOTS; s++) begin
                rd_data = rd_data | (view[k][s*DW +: DW] & {DW{sel[k][s]}});
            end
        end
    end

    // Edges are masked until the arming timer hits terminal count.
    assign armed = (arm_cnt_q == '0);
    assign rise  = sync_v & ~prev_q & {NW{armed}};
    assign fall  = ~sync_v & prev_q & {NW{armed}};
    assign set_v = (rise & rise_en_q) | (fall & fall_en_q);
    assign clr_v = wvec & we_clr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            stat_q     <= '0;
            mask_q     <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            arm_cnt_q  <= ARM_LOAD;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            out_q     <= (out_q & ~we_out) | (wvec & we_out);
            dir_q     <= (dir_q & ~we_dir) | (wvec & we_dir);
            mask_q    <= (mask_q & ~we_mask) | (wvec & we_mask);
            rise_en_q <= (rise_en_q & ~we_rise) | (wvec & we_rise);
            fall_en_q <= (fall_en_q & ~we_fall) | (wvec & we_fall);
            // A set in the same cycle as a clear wins.
            stat_q    <= (stat_q & ~clr_v) | set_v;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q    <= sync_v;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q - 1'b1;
            end
            // Read data comes from pre-write state, so a same-cycle write is not visible.
            if (bus_re) begin
                bus_rdata <= rd_data;
            end
            bus_rvalid <= bus_re;
            irq        <= |(stat_q & mask_q);
        end
    end

    assign pad_o  = out_q;
    assign pad_oe = dir_q;

endmodule

// File: tb/tb_dio_slot_bank.sv
// Testbench for dio_slot_bank with two 16-bit slots.
module tb_dio_slot_bank;

    localparam int SLOTS = 2;
    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int SS    = 2;
    localparam int NW    = SLOTS * DW;

    logic          clk;
    logic          sys_rst;
    logic          bus_we;
    logic          bus_re;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_rvalid;
    logic [NW-1:0] pad_o;
    logic [NW-1:0] pad_oe;
    logic [NW-1:0] pad_i;
    logic          irq;

    int total = 0;
    int bad   = 0;

    dio_slot_bank #(.SLOTS(SLOTS), .DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .pad_o     (pad_o),
        .pad_oe    (pad_oe),
        .pad_i     (pad_i),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: registers held as whole-bank vectors, pad history
    // as a delay line of samples since reset (older samples read as 0).
    logic [NW-1:0] m_out, m_dir, m_stat, m_mask, m_rise, m_fall;
    logic [NW-1:0] hist [0:SS];
    int            cyc;
    logic [DW-1:0] e_rdata;
    logic          e_rvalid, e_irq;
    bit            model_live = 1'b0;

    function automatic logic [DW-1:0] model_read(input int a, input logic [NW-1:0] sv);
        logic [NW-1:0] v;
        int k, s;
        if (a >= 8 * SLOTS) return '0;
        k = a / SLOTS;
        s = a % SLOTS;
        case (k)
            0: v = m_out;
            1: v = sv;
            2: v = m_dir;
            3: v = m_stat;
            4: v = m_mask;
            6: v = m_rise;
            7: v = m_fall;
            default: v = '0;
        endcase
        return v[s*DW +: DW];
    endfunction

    task automatic model_step();
        logic [NW-1:0] sv, pv, rs, fl, clr, setv;
        int a, k, s;
        if (sys_rst) begin
            m_out = '0; m_dir = '0; m_stat = '0; m_mask = '0;
            m_rise = '1; m_fall = '0;
            for (int i = 0; i <= SS; i++) hist[i] = '0;
            cyc = 0;
            e_rdata = '0; e_rvalid = 1'b0; e_irq = 1'b0;
            model_live = 1'b1;
        end else begin
            sv = hist[SS-1];
            pv = hist[SS];
            if (cyc >= SS + 1) begin
                rs = sv & ~pv;
                fl = ~sv & pv;
            end else begin
                rs = '0;
                fl = '0;
            end
            setv = (rs & m_rise) | (fl & m_fall);
            e_irq = |(m_stat & m_mask);
            e_rvalid = bus_re;
            a = int'(bus_addr);
            if (bus_re) e_rdata = model_read(a, sv);
            clr = '0;
            if (bus_we && a < 8 * SLOTS) begin
                k = a / SLOTS;
                s = a % SLOTS;
                case (k)
                    0: m_out[s*DW +: DW]  = bus_wdata;
                    2: m_dir[s*DW +: DW]  = bus_wdata;
                    4: m_mask[s*DW +: DW] = bus_wdata;
                    5: clr[s*DW +: DW]    = bus_wdata;
                    6: m_rise[s*DW +: DW] = bus_wdata;
                    7: m_fall[s*DW +: DW] = bus_wdata;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | setv;
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pad_i;
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check("cmp_pad_o", pad_o, m_out);
            check("cmp_pad_oe", pad_oe, m_dir);
            check("cmp_irq", {31'b0, irq}, {31'b0, e_irq});
            check("cmp_rvalid", {31'b0, bus_rvalid}, {31'b0, e_rvalid});
            check("cmp_rdata", {16'b0, bus_rdata}, {16'b0, e_rdata});
        end
    end

    // All bus tasks start and end #1 after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        bus_we = 1'b1; bus_addr = AW'(addr); bus_wdata = data;
        step(1);
        bus_we = 1'b0;
    endtask

    task automatic rd(input string name, input int addr, input logic [DW-1:0] exp);
        bus_re = 1'b1; bus_addr = AW'(addr);
        step(1);
        bus_re = 1'b0;
        check({name, "_rvalid"}, {31'b0, bus_rvalid}, 32'd1);
        check(name, {16'b0, bus_rdata}, {16'b0, exp});
        step(1);
        check({name, "_rvalid_drop"}, {31'b0, bus_rvalid}, 32'd0);
    endtask

    task automatic wr_rd(input int addr, input logic [DW-1:0] data, input logic [DW-1:0] exp);
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = AW'(addr); bus_wdata = data;
        step(1);
        bus_we = 1'b0; bus_re = 1'b0;
        check("same_cycle_rvalid", {31'b0, bus_rvalid}, 32'd1);
        check("same_cycle_old", {16'b0, bus_rdata}, {16'b0, exp});
    endtask

    logic [DW-1:0] pats [6] = '{16'hAAAA, 16'h5555, 16'h0000, 16'hFFFF, 16'h8000, 16'h0001};

    initial begin
        sys_rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = '0; bus_wdata = '0; pad_i = '0;
        step(3);
        check("rst_pad_o", pad_o, 32'h0);
        check("rst_pad_oe", pad_oe, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rvalid", {31'b0, bus_rvalid}, 32'd0);
        check("rst_rdata", {16'b0, bus_rdata}, 32'd0);
        sys_rst = 1'b0;
        rd("rst_rise_en1", 13, 16'hFFFF);
        rd("rst_fall_en0", 14, 16'h0000);
        rd("rst_dir0", 4, 16'h0000);

        // Write/readback on each slot
        for (int s = 0; s < SLOTS; s++) begin
            for (int p = 0; p < 6; p++) begin
                wr(s, pats[p]);
                rd("out_readback", s, pats[p]);
            end
        end

        // Direction and output pads
        wr(4, 16'hFFFF);
        wr(0, 16'h5555);
        check("pad_oe_s0", {16'b0, pad_oe[15:0]}, 32'h0000FFFF);
        check("pad_o_s0", {16'b0, pad_o[15:0]}, 32'h00005555);
        wr(4, 16'h0000);
        check("pad_oe_off", {16'b0, pad_oe[15:0]}, 32'h0);
        wr_rd(0, 16'h1234, 16'h5555);
        rd("out_after_same", 0, 16'h1234);

        // Input synchronisation latency and out-of-range addresses
        pad_i = 32'h0000_8001;
        step(1);
        rd("in_too_early", 2, 16'h0000);
        rd("in_synced", 2, 16'h8001);
        rd("addr_oob", 16, 16'h0000);
        rd("addr_max", 127, 16'h0000);
        wr(16, 16'hFFFF);
        rd("oob_write_ignored", 0, 16'h1234);

        // Rising edge interrupt with latency
        pad_i = '0;
        step(4);
        wr(10, 16'hFFFF);
        wr(8, 16'hFFFF);
        rd("stat_cleared", 6, 16'h0000);
        pad_i = 32'h0000_0001;
        step(3);
        check("irq_not_yet", {31'b0, irq}, 32'd0);
        step(1);
        check("irq_rise", {31'b0, irq}, 32'd1);
        rd("stat_rise", 6, 16'h0001);
        wr(10, 16'hFFFF);
        check("irq_clr_lag", {31'b0, irq}, 32'd1);
        step(1);
        check("irq_clr", {31'b0, irq}, 32'd0);
        rd("stat_after_clr", 6, 16'h0000);

        // Falling edge
        wr(14, 16'h0001);
        pad_i = '0;
        step(4);
        rd("stat_fall", 6, 16'h0001);
        wr(10, 16'hFFFF);

        // Mask gating
        wr(14, 16'h0000);
        wr(8, 16'h0000);
        pad_i = 32'h0000_0001;
        step(5);
        check("irq_masked", {31'b0, irq}, 32'd0);
        rd("stat_masked", 6, 16'h0001);
        wr(8, 16'h0001);
        check("irq_unmask_lag", {31'b0, irq}, 32'd0);
        step(1);
        check("irq_unmask", {31'b0, irq}, 32'd1);
        wr(10, 16'hFFFF);
        pad_i = '0;
        step(4);
        wr(10, 16'hFFFF);

        // Set and clear in the same cycle: set wins
        pad_i = 32'h0000_0001;
        step(2);
        wr(10, 16'hFFFF);
        rd("set_wins", 6, 16'h0001);

        // Reset during a read, pads held high through reset
        wr(4, 16'hFFFF);
        pad_i = '1;
        bus_re = 1'b1; bus_addr = AW'(0); sys_rst = 1'b1;
        step(1);
        bus_re = 1'b0;
        check("midrst_rvalid", {31'b0, bus_rvalid}, 32'd0);
        check("midrst_pad_o", pad_o, 32'h0);
        check("midrst_pad_oe", pad_oe, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        check("midrst_rdata", {16'b0, bus_rdata}, 32'd0);
        step(1);
        sys_rst = 1'b0;
        wr(8, 16'hFFFF);
        wr(9, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("no_irq_after_rst", {31'b0, irq}, 32'd0);
        end
        rd("stat0_after_rst", 6, 16'h0000);
        rd("stat1_after_rst", 7, 16'h0000);
        rd("in1_high", 3, 16'hFFFF);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
